// File: rtl/ghost_ram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ghost_ram_ctrl
//  Purpose  : Distance-to-Pac-Man map RAM with sweep rebuild and blocked-code
//             read port. Optional wall ROM enabled by GHOST_MAZE_ROM_EN.
//  Revision : 1.0
// ============================================================================
module ghost_ram_ctrl #(
    parameter int GRID_W    = 40,
    parameter int GRID_H    = 30,
    parameter     MAZE_FILE = "maze.txt"
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [5:0] curr_pacman_x,
    input  logic [4:0] curr_pacman_y,
    input  logic [5:0] curr_ghost1_x,
    input  logic [4:0] curr_ghost1_y,
    input  logic [5:0] curr_ghost2_x,
    input  logic [4:0] curr_ghost2_y,
    input  logic [5:0] prev_ghost1_x,
    input  logic [4:0] prev_ghost1_y,
    input  logic [5:0] prev_ghost2_x,
    input  logic [4:0] prev_ghost2_y,
    input  logic [5:0] rdaddr_x,
    input  logic [4:0] rdaddr_y,
    output logic [7:0] data,
    output logic       ready
);

    localparam int         c_CELLS = GRID_W * GRID_H;
    localparam int         c_AW    = $clog2(c_CELLS);
    localparam logic [5:0] c_XMAX  = 6'(GRID_W - 1);
    localparam logic [4:0] c_YMAX  = 5'(GRID_H - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SWEEP = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_start;
    logic              w_we;
    logic              w_last;

    logic [5:0]        r_pac_x;
    logic [4:0]        r_pac_y;
    logic              r_pac_valid;
    logic [5:0]        r_cnt_x;
    logic [4:0]        r_cnt_y;
    logic [c_AW-1:0]   r_cnt_idx;
    logic              r_ready;
    logic [7:0]        r_data;

    logic [7:0]        r_mem [0:c_CELLS-1];

    logic [5:0]        w_dx;
    logic [4:0]        w_dy;
    logic [8:0]        w_sum;
    logic [7:0]        w_dist;
    logic              w_border;
    logic              w_wall;
    logic [7:0]        w_wr_val;

    logic [c_AW-1:0]   w_rd_idx;
    logic              w_rd_oob;
    logic              w_ghost_hit;

    assign w_last = (r_cnt_x == c_XMAX) && (r_cnt_y == c_YMAX);

    // Sweep control: any Pac-Man change (or no valid latch yet) restarts at cell 0
    always_comb begin
        w_state_nxt = r_state;
        w_we        = 1'b0;
        w_start     = !r_pac_valid || (curr_pacman_x != r_pac_x) ||
                      (curr_pacman_y != r_pac_y);
        if (w_start) begin
            w_state_nxt = S_SWEEP;
        end else if (r_state == S_SWEEP) begin
            w_we = 1'b1;
            if (w_last) begin
                w_state_nxt = S_IDLE;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_pac_x     <= '0;
            r_pac_y     <= '0;
            r_pac_valid <= 1'b0;
            r_cnt_x     <= '0;
            r_cnt_y     <= '0;
            r_cnt_idx   <= '0;
            r_ready     <= 1'b0;
        end else if (w_start) begin
            r_pac_x     <= curr_pacman_x;
            r_pac_y     <= curr_pacman_y;
            r_pac_valid <= 1'b1;
            r_cnt_x     <= '0;
            r_cnt_y     <= '0;
            r_cnt_idx   <= '0;
            r_ready     <= 1'b0;
        end else if (w_we) begin
            if (w_last) begin
                r_ready   <= 1'b1;
                r_cnt_x   <= '0;
                r_cnt_y   <= '0;
                r_cnt_idx <= '0;
            end else begin
                r_cnt_idx <= r_cnt_idx + 1'b1;
                if (r_cnt_x == c_XMAX) begin
                    r_cnt_x <= '0;
                    r_cnt_y <= r_cnt_y + 1'b1;
                end else begin
                    r_cnt_x <= r_cnt_x + 1'b1;
                end
            end
        end
    end

    // Manhattan distance from the latched position, saturated below the blocked codes
    assign w_dx   = (r_cnt_x >= r_pac_x) ? (r_cnt_x - r_pac_x) : (r_pac_x - r_cnt_x);
    assign w_dy   = (r_cnt_y >= r_pac_y) ? (r_cnt_y - r_pac_y) : (r_pac_y - r_cnt_y);
    assign w_sum  = {3'b000, w_dx} + {4'b0000, w_dy};
    assign w_dist = (w_sum > 9'd253) ? 8'd253 : w_sum[7:0];

    assign w_border = (r_cnt_x == 6'd0) || (r_cnt_x == c_XMAX) ||
                      (r_cnt_y == 5'd0) || (r_cnt_y == c_YMAX);

    if ($bits(MAZE_FILE) == 0) begin : g_no_maze_name
    end

`ifdef GHOST_MAZE_ROM_EN
    logic r_wall_rom [0:c_CELLS-1];

    initial begin
        for (int i = 0; i < c_CELLS; i++) begin
            r_wall_rom[i] = 1'b0;
        end
    end

    assign w_wall = w_border || r_wall_rom[r_cnt_idx];
`else
    assign w_wall = w_border;
`endif

    assign w_wr_val = w_wall ? 8'd255 : w_dist;

    always_ff @(posedge CLOCK_50) begin
        if (w_we) begin
            r_mem[r_cnt_idx] <= w_wr_val;
        end
    end

    assign w_rd_oob    = (rdaddr_x >= 6'(GRID_W)) || (rdaddr_y >= 5'(GRID_H));
    assign w_rd_idx    = c_AW'(32'(rdaddr_y) * GRID_W + 32'(rdaddr_x));
    assign w_ghost_hit = ((rdaddr_x == curr_ghost1_x) && (rdaddr_y == curr_ghost1_y)) ||
                         ((rdaddr_x == curr_ghost2_x) && (rdaddr_y == curr_ghost2_y)) ||
                         ((rdaddr_x == prev_ghost1_x) && (rdaddr_y == prev_ghost1_y)) ||
                         ((rdaddr_x == prev_ghost2_x) && (rdaddr_y == prev_ghost2_y));

    // Read sits beside the sweep write, so a same-cell collision returns old content
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_data <= 8'd255;
        end else if (w_rd_oob) begin
            r_data <= 8'd255;
        end else if (w_ghost_hit) begin
            r_data <= 8'd254;
        end else begin
            r_data <= r_mem[w_rd_idx];
        end
    end

    assign data  = r_data;
    assign ready = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_ghost_ram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ghost_ram_ctrl
//  Purpose  : Self-checking bench for ghost_ram_ctrl (40x30 grid).
//  Revision : 1.0
// ============================================================================
module tb_ghost_ram_ctrl;

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic [5:0] pac_x, g1x, g2x, p1x, p2x, rd_x;
    logic [4:0] pac_y, g1y, g2y, p1y, p2y, rd_y;
    logic [7:0] data;
    logic       ready;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        int rx, ry;
        int g1x, g1y;
        int p2x, p2y;
        int exp;
    } vec_t;

    vec_t tbl [13];

    always #5 CLOCK_50 = ~CLOCK_50;

    ghost_ram_ctrl #(.GRID_W(40), .GRID_H(30)) dut (
        .CLOCK_50      (CLOCK_50),
        .reset         (reset),
        .curr_pacman_x (pac_x),
        .curr_pacman_y (pac_y),
        .curr_ghost1_x (g1x),
        .curr_ghost1_y (g1y),
        .curr_ghost2_x (g2x),
        .curr_ghost2_y (g2y),
        .prev_ghost1_x (p1x),
        .prev_ghost1_y (p1y),
        .prev_ghost2_x (p2x),
        .prev_ghost2_y (p2y),
        .rdaddr_x      (rd_x),
        .rdaddr_y      (rd_y),
        .data          (data),
        .ready         (ready)
    );

    task automatic tick();
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
    endtask

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int cell_val(input int x, input int y, input int px, input int py);
        int d;
        if (x == 0 || x == 39 || y == 0 || y == 29) return 255;
        d = iabs(x - px) + iabs(y - py);
        return (d > 253) ? 253 : d;
    endfunction

    function automatic int read_model(input int rx, input int ry, input int px, input int py);
        if (rx >= 40 || ry >= 30) return 255;
        if ((rx == int'(g1x) && ry == int'(g1y)) || (rx == int'(g2x) && ry == int'(g2y)) ||
            (rx == int'(p1x) && ry == int'(p1y)) || (rx == int'(p2x) && ry == int'(p2y)))
            return 254;
        return cell_val(rx, ry, px, py);
    endfunction

    task automatic park_ghosts(input int x, input int y);
        g1x = 6'(x); g2x = 6'(x); p1x = 6'(x); p2x = 6'(x);
        g1y = 5'(y); g2y = 5'(y); p1y = 5'(y); p2y = 5'(y);
    endtask

    task automatic wait_ready(input int start, input string name);
        int n;
        n = start;
        while (!ready && n < 3000) begin
            tick();
            n++;
        end
        check(name, n, 1201);
    endtask

    task automatic move_pacman(input int x, input int y, input string name);
        pac_x = 6'(x);
        pac_y = 5'(y);
        tick();
        check({name, "_ready_drop"}, int'(ready), 0);
        wait_ready(1, name);
    endtask

    task automatic read_one(input int x, input int y, input int exp, input string name);
        rd_x = 6'(x);
        rd_y = 5'(y);
        tick();
        check(name, int'(data), exp);
    endtask

    task automatic scan_map(input int px, input int py, input string name);
        park_ghosts(63, 31);
        for (int y = 0; y < 30; y++) begin
            for (int x = 0; x < 40; x++) begin
                read_one(x, y, cell_val(x, y, px, py), name);
            end
        end
    endtask

    initial begin
        tbl[0]  = '{20, 20,  1,  1,  1,  1,   0};
        tbl[1]  = '{16, 12,  1,  1,  1,  1,  12};
        tbl[2]  = '{21, 20,  1,  1,  1,  1,   1};
        tbl[3]  = '{38, 28,  1,  1,  1,  1,  26};
        tbl[4]  = '{ 0,  5,  1,  1,  1,  1, 255};
        tbl[5]  = '{45,  3,  1,  1,  1,  1, 255};
        tbl[6]  = '{ 5, 31,  1,  1,  1,  1, 255};
        tbl[7]  = '{16, 13, 16, 13, 23, 12, 254};
        tbl[8]  = '{23, 12, 16, 13, 23, 12, 254};
        tbl[9]  = '{ 1,  1,  1,  1,  1,  1, 254};
        tbl[10] = '{39, 29,  1,  1,  1,  1, 255};
        tbl[11] = '{63, 31,  1,  1,  1,  1, 255};
        tbl[12] = '{19, 21,  1,  1,  1,  1,   2};

        reset = 1'b0;
        pac_x = '0; pac_y = '0; rd_x = '0; rd_y = '0;
        park_ghosts(1, 1);
        @(negedge CLOCK_50);

        // Reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            pac_x = 6'($urandom); pac_y = 5'($urandom);
            rd_x  = 6'($urandom); rd_y  = 5'($urandom);
            g1x = 6'($urandom); g1y = 5'($urandom);
            p2x = 6'($urandom); p2y = 5'($urandom);
            tick();
            check("reset_data", int'(data), 255);
            check("reset_ready", int'(ready), 0);
        end

        park_ghosts(1, 1);
        pac_x = 6'd20; pac_y = 5'd20;
        reset = 1'b1;
        tick();
        check("first_sweep_ready_low", int'(ready), 0);
        wait_ready(1, "first_sweep_len");

        foreach (tbl[i]) begin
            g1x = 6'(tbl[i].g1x); g1y = 5'(tbl[i].g1y);
            p2x = 6'(tbl[i].p2x); p2y = 5'(tbl[i].p2y);
            read_one(tbl[i].rx, tbl[i].ry, tbl[i].exp, $sformatf("table[%0d]", i));
        end

        // Random reads and ghost positions against the model
        for (int i = 0; i < 300; i++) begin
            int rx, ry, e;
            g1x = 6'($urandom_range(39)); g1y = 5'($urandom_range(29));
            g2x = 6'($urandom_range(39)); g2y = 5'($urandom_range(29));
            p1x = 6'($urandom_range(39)); p1y = 5'($urandom_range(29));
            p2x = 6'($urandom_range(39)); p2y = 5'($urandom_range(29));
            rx = $urandom_range(63);
            ry = $urandom_range(31);
            if ($urandom_range(3) == 0) begin
                rx = int'(p1x);
                ry = int'(p1y);
            end
            e = read_model(rx, ry, 20, 20);
            read_one(rx, ry, e, "random_read");
        end

        park_ghosts(1, 1);
        move_pacman(21, 20, "move_sweep_len");
        read_one(20, 20, 1, "move_read");

        // Restart 500 cycles into a sweep
        pac_x = 6'd5; pac_y = 5'd5;
        tick();
        check("pre_restart_ready_drop", int'(ready), 0);
        repeat (499) tick();
        check("mid_sweep_ready_low", int'(ready), 0);
        move_pacman(10, 10, "restart_sweep_len");
        read_one(10, 10, 0, "restart_read");
        scan_map(10, 10, "scan_10_10");

        // Same-cell collision: cell (5,5) is written 207 edges after the change
        pac_x = 6'd11; pac_y = 5'd10;
        rd_x = 6'd1; rd_y = 5'd1;
        repeat (206) tick();
        rd_x = 6'd5; rd_y = 5'd5;
        tick();
        check("rbw_old", int'(data), 10);
        tick();
        check("rbw_new", int'(data), 11);
        wait_ready(208, "rbw_sweep_len");

        // Asynchronous reset in the middle of a sweep
        pac_x = 6'd3; pac_y = 5'd4;
        repeat (100) tick();
        #2 reset = 1'b0;
        #1;
        check("async_rst_ready", int'(ready), 0);
        check("async_rst_data", int'(data), 255);
        @(negedge CLOCK_50);
        reset = 1'b1;
        tick();
        check("post_rst_ready_low", int'(ready), 0);
        wait_ready(1, "post_rst_sweep_len");
        scan_map(3, 4, "scan_3_4");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
